// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - op codes, FSM states and shared constants for alu_seq
package alu_seq_pkg;

  localparam int OP_W        = 5;
  localparam int MULDIV_BASE = 16;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_AND    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_XOR    = 5'd4,
    ALU_SLT    = 5'd5,
    ALU_SLL    = 5'd6,
    ALU_SRL    = 5'd7,
    ALU_SRA    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_JALR   = 5'd10,
    ALU_LUI    = 5'd11,
    ALU_AUIPC  = 5'd12,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/alu_seq_mdu.sv
// rtl/alu_seq_mdu.sv - iterative shift-add multiplier / restoring divider
// done is raised while the last step is in flight; result already includes that step.
module alu_seq_mdu
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   cnt;
  logic               active;
  logic               is_div;
  logic               want_hi;
  logic               neg_main;
  logic               neg_rem;

  logic               a_signed;
  logic               b_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    a_signed = op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
    b_signed = op inside {ALU_MUL, ALU_MULH, ALU_DIV, ALU_REM};
    a_neg    = a_signed && a[WIDTH-1];
    b_neg    = b_signed && b[WIDTH-1];
    mag_a    = a_neg ? -a : a;
    mag_b    = b_neg ? -b : b;
  end

  // Multiply keeps the multiplier in the low half and shifts right; divide keeps
  // {remainder, dividend/quotient} and shifts left one bit per step.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_sh - {1'b0, mcand};
    if (is_div)
      acc_next = {(div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                  acc[WIDTH-2:0], ~div_diff[WIDTH]};
    else
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    prod = neg_main ? -acc_next : acc_next;
    quo  = neg_main ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    rem  = neg_rem ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    if (is_div)
      result = want_hi ? rem : quo;
    else
      result = want_hi ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
  end

  assign done = active && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      mcand    <= '0;
      cnt      <= '0;
      active   <= 1'b0;
      is_div   <= 1'b0;
      want_hi  <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
    end else if (start) begin
      acc      <= {{WIDTH{1'b0}}, mag_a};
      mcand    <= mag_b;
      cnt      <= '0;
      active   <= 1'b1;
      is_div   <= op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
      want_hi  <= op inside {ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_REM, ALU_REMU};
      neg_main <= a_neg ^ b_neg;
      neg_rem  <= a_neg;
    end else if (active) begin
      acc <= acc_next;
      if (cnt == LAST)
        active <= 1'b0;
      else
        cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle RV32IM ALU with valid/ready operand and result handshakes
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rslt,
  output logic             zero,
  output logic             busy
);

  state_t           state;
  alu_op_t          op_e;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] base_rslt;
  logic [WIDTH-1:0] spec_rslt;
  logic [WIDTH-1:0] imm_rslt;
  logic             is_muldiv;
  logic             is_mul;
  logic             is_div;
  logic             want_rem;
  logic             signed_div;
  logic             div_by_zero;
  logic             div_ovf;
  logic             special;
  logic             mdu_start;
  logic             mdu_done;
  logic [WIDTH-1:0] mdu_result;

  assign op_e  = alu_op_t'(op);
  assign shamt = b[SHW-1:0];

  always_comb begin
    case (op_e)
      ALU_ADD:   base_rslt = a + b;
      ALU_SUB:   base_rslt = a - b;
      ALU_AND:   base_rslt = a & b;
      ALU_OR:    base_rslt = a | b;
      ALU_XOR:   base_rslt = a ^ b;
      ALU_SLT:   base_rslt = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLL:   base_rslt = a << shamt;
      ALU_SRL:   base_rslt = a >> shamt;
      ALU_SRA:   base_rslt = $signed(a) >>> shamt;
      ALU_SLTU:  base_rslt = {{(WIDTH-1){1'b0}}, a < b};
      ALU_JALR:  base_rslt = (a + b) & ~{{(WIDTH-1){1'b0}}, 1'b1};
      ALU_LUI:   base_rslt = b;
      ALU_AUIPC: base_rslt = a + b;
      default:   base_rslt = '0;
    endcase
  end

  // Divide corner cases bypass the iteration entirely.
  always_comb begin
    is_muldiv   = (op >= OP_W'(MULDIV_BASE)) && (op < OP_W'(MULDIV_BASE + 8));
    is_mul      = is_muldiv && !op[2];
    is_div      = is_muldiv && op[2];
    want_rem    = op_e inside {ALU_REM, ALU_REMU};
    signed_div  = op_e inside {ALU_DIV, ALU_REM};
    div_by_zero = (b == '0);
    div_ovf     = signed_div && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    special     = is_div && (div_by_zero || div_ovf);
    if (div_by_zero)
      spec_rslt = want_rem ? a : '1;
    else
      spec_rslt = want_rem ? '0 : a;
    imm_rslt  = special ? spec_rslt : base_rslt;
    mdu_start = (state == IDLE) && in_valid && (is_mul || (is_div && !special));
  end

  alu_seq_mdu #(.WIDTH(WIDTH)) u_mdu (
    .clk    (clk),
    .rst    (rst),
    .start  (mdu_start),
    .op     (op_e),
    .a      (a),
    .b      (b),
    .done   (mdu_done),
    .result (mdu_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rslt  <= '0;
      zero  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_mul) begin
              state <= MUL;
            end else if (is_div && !special) begin
              state <= DIV;
            end else begin
              state <= DONE;
              rslt  <= imm_rslt;
              zero  <= (imm_rslt == '0);
            end
          end
        end
        MUL, DIV: begin
          if (mdu_done) begin
            state <= DONE;
            rslt  <= mdu_result;
            zero  <= (mdu_result == '0);
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == MUL) || (state == DIV);

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed vector bench for alu_seq
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  op = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] rslt;
  logic        zero;
  logic        busy;

  int passed = 0;
  int total  = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rslt      (rslt),
    .zero      (zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(string n, logic [4:0] o, logic [31:0] va,
                                  logic [31:0] vb, logic [31:0] e, int l);
    vec_t v;
    v.name = n; v.op = o; v.a = va; v.b = vb; v.exp = e; v.lat = l;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic [4:0] top, output logic [31:0] r,
                        output logic z, output int lat, output int nb);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    a = ta; b = tb_v; op = top; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    nb  = 0;
    while (!out_valid && lat < 200) begin
      if (busy) nb++;
      @(negedge clk);
      lat++;
    end
    r = rslt;
    z = zero;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [31:0] r;
  logic        z;
  int          lat;
  int          nb;
  int          ov_seen;

  initial begin
    add_vec("add",     5'd0,  32'd3,        32'd4,        32'd7,        1);
    add_vec("sub_neg", 5'd1,  32'd3,        32'd5,        32'hFFFFFFFE, 1);
    add_vec("and",     5'd2,  32'hF0F0,     32'hFF00,     32'hF000,     1);
    add_vec("or",      5'd3,  32'hF0F0,     32'h0F00,     32'hFFF0,     1);
    add_vec("xor",     5'd4,  32'hFF,       32'h0F,       32'hF0,       1);
    add_vec("slt",     5'd5,  32'hFFFFFFFF, 32'd1,        32'd1,        1);
    add_vec("sll_msk", 5'd6,  32'd1,        32'h21,       32'd2,        1);
    add_vec("srl",     5'd7,  32'h80000000, 32'd4,        32'h08000000, 1);
    add_vec("sra",     5'd8,  32'h80000000, 32'd4,        32'hF8000000, 1);
    add_vec("sltu",    5'd9,  32'hFFFFFFFF, 32'd1,        32'd0,        1);
    add_vec("jalr",    5'd10, 32'h1001,     32'h4,        32'h1004,     1);
    add_vec("lui",     5'd11, 32'd5,        32'h12345000, 32'h12345000, 1);
    add_vec("auipc",   5'd12, 32'h1000,     32'h2000,     32'h3000,     1);
    add_vec("rsv13",   5'd13, 32'd1,        32'd2,        32'd0,        1);
    add_vec("rsv31",   5'd31, 32'd1,        32'd2,        32'd0,        1);
    add_vec("mul",     5'd16, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    add_vec("mulhu",   5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    add_vec("mulh",    5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    add_vec("mulhsu",  5'd18, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    add_vec("div_ovf", 5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    add_vec("rem_ovf", 5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    add_vec("divu_z",  5'd21, 32'h1234,     32'd0,        32'hFFFFFFFF, 1);
    add_vec("remu_z",  5'd23, 32'h1234,     32'd0,        32'h1234,     1);
    add_vec("rem_neg", 5'd22, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    add_vec("div_neg", 5'd20, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    add_vec("divu",    5'd21, 32'd100,      32'd7,        32'd14,       33);
    add_vec("remu",    5'd23, 32'd100,      32'd7,        32'd2,        33);
    add_vec("div_z",   5'd20, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_rslt",      rslt,           32'd0);
    check("rst_zero",      32'(zero),      32'd1);

    // SUB to zero, then hold the result with out_ready low
    run_op(32'd5, 32'd5, 5'd1, r, z, lat, nb);
    check("sub0_lat",  32'(lat), 32'd1);
    check("sub0_rslt", r,        32'd0);
    check("sub0_zero", 32'(z),   32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_rslt",  rslt,           32'd0);
      check("hold_ready", 32'(in_ready),  32'd0);
    end
    release_result();
    check("bubble_in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, r, z, lat, nb);
      check({vecs[i].name, "_rslt"}, r, vecs[i].exp);
      check({vecs[i].name, "_zero"}, 32'(z), 32'(vecs[i].exp == 32'd0));
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      check({vecs[i].name, "_busy_cycles"}, 32'(nb), 32'(vecs[i].lat - 1));
      check({vecs[i].name, "_busy_done"}, 32'(busy), 32'd0);
      release_result();
    end

    // reset in the middle of a divide abandons it
    a = 32'd100; b = 32'd7; op = 5'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("div_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("post_rst_in_ready",  32'(in_ready),  32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_rslt",      rslt,           32'd0);
    check("post_rst_zero",      32'(zero),      32'd1);
    ov_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check("post_rst_no_result", 32'(ov_seen), 32'd0);

    run_op(32'd3, 32'd4, 5'd0, r, z, lat, nb);
    check("post_rst_add_rslt", r,        32'd7);
    check("post_rst_add_lat",  32'(lat), 32'd1);
    release_result();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
